lsu_mmio: RTL and testbench

- Parametrised load/store unit for the RV32I core: byte-addressed data memory plus memory-mapped peripherals.
- Peripherals are NUM_HEX hex-display registers and a synchronised switch bank.
- Requests use a valid handshake. Every request gets a registered response one cycle later, with sign/zero-extended load data and an error flag for misaligned or unmapped accesses.
- Sits between the execute stage and the board I/O. Replaces the fixed-map, combinational-read LSU.

---
 rtl/lsu_mmio_if.sv | 23 ++
 rtl/lsu_mmio.sv | 141 ++++++++++++++
 tb/tb_lsu_mmio.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mmio_if.sv
// rtl/lsu_mmio_if.sv - request/response bundle between the execute stage and lsu_mmio
interface lsu_mmio_if #(
  parameter int unsigned AW = 12
);
  logic          req_valid_i;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic [2:0]    req_funct3_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    input  resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    output resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/lsu_mmio.sv
// rtl/lsu_mmio.sv - RV32I load/store unit: data memory, hex and switch MMIO; LSU_TIMER_EN adds a cycle timer
module lsu_mmio #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DM_BYTES  = 2048,
  parameter int unsigned NUM_HEX   = 8,
  parameter int unsigned SW_W      = 8,
  parameter int unsigned PERI_BASE = 'h800
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  lsu_mmio_if.slave              bus,
  input  logic [SW_W-1:0]        io_sw_i,
  output logic [32*NUM_HEX-1:0]  io_hex_o
);
  localparam int unsigned DM_WORDS = DM_BYTES / 4;
  localparam int unsigned DM_IW    = $clog2(DM_WORDS);
  localparam int unsigned HEX_IW   = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;
  localparam int unsigned PERI_WA  = PERI_BASE / 4;
  localparam int unsigned SW_WA    = (PERI_BASE + 'h80) / 4;

  logic [31:0]       dm_q [DM_WORDS];
  logic [31:0]       hex_q [NUM_HEX];
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic [2:0]        f3;
  logic [1:0]        off;
  logic [31:0]       wa;
  logic [DM_IW-1:0]  dm_idx;
  logic [HEX_IW-1:0] hex_idx;
  logic              hit_dm, hit_hex, hit_sw, hit_tmr;
  logic              bad_f3, misal, err_d, wr_en;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, word_rd, lane, rdata_d, tmr_rd;

  assign f3      = bus.req_funct3_i;
  assign off     = bus.req_addr_i[1:0];
  assign wa      = 32'(bus.req_addr_i[AW-1:2]);
  assign dm_idx  = bus.req_addr_i[DM_IW+1:2];
  assign hex_idx = HEX_IW'(wa - PERI_WA);

  // Decode on the full word address so nothing aliases into a mapped region
  assign hit_dm  = wa < DM_WORDS;
  assign hit_hex = (wa >= PERI_WA) && (wa < PERI_WA + NUM_HEX);
  assign hit_sw  = wa == SW_WA;

`ifdef LSU_TIMER_EN
  localparam int unsigned TMR_WA = (PERI_BASE + 'h90) / 4;
  logic [31:0] tmr_q;
  assign hit_tmr = wa == TMR_WA;
  assign tmr_rd  = tmr_q;
`else
  assign hit_tmr = 1'b0;
  assign tmr_rd  = '0;
`endif

  always_comb begin
    bad_f3    = 1'b0;
    misal     = 1'b0;
    be        = 4'b0000;
    wdata_rep = bus.req_wdata_i;
    case (f3)
      3'b000, 3'b100: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{bus.req_wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        misal     = off[0];
        be        = 4'b0011 << off;
        wdata_rep = {2{bus.req_wdata_i[15:0]}};
      end
      3'b010: begin
        misal = |off;
        be    = 4'b1111;
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  // The switch bank is read-only and the timer only takes whole-word stores
  assign err_d = bad_f3 | misal | ~(hit_dm | hit_hex | hit_sw | hit_tmr)
               | (bus.req_we_i & hit_sw)
               | (bus.req_we_i & hit_tmr & (f3 != 3'b010));
  assign wr_en = bus.req_valid_i & bus.req_we_i & ~err_d;

  always_comb begin
    word_rd = '0;
    if (hit_dm)       word_rd = dm_q[dm_idx];
    else if (hit_hex) word_rd = hex_q[hex_idx];
    else if (hit_sw)  word_rd = 32'(sw_sync_q);
    else if (hit_tmr) word_rd = tmr_rd;
    lane = word_rd >> {off, 3'b000};
    case (f3)
      3'b000:  rdata_d = {{24{lane[7]}}, lane[7:0]};
      3'b100:  rdata_d = {24'b0, lane[7:0]};
      3'b001:  rdata_d = {{16{lane[15]}}, lane[15:0]};
      3'b101:  rdata_d = {16'b0, lane[15:0]};
      3'b010:  rdata_d = lane;
      default: rdata_d = '0;
    endcase
    if (bus.req_we_i || err_d) rdata_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.resp_err_o   <= 1'b0;
      sw_meta_q        <= '0;
      sw_sync_q        <= '0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= '0;
    end else begin
      bus.resp_valid_o <= bus.req_valid_i;
      bus.resp_rdata_o <= bus.req_valid_i ? rdata_d : '0;
      bus.resp_err_o   <= bus.req_valid_i & err_d;
      sw_meta_q        <= io_sw_i;
      sw_sync_q        <= sw_meta_q;
      if (wr_en && hit_hex)
        for (int b = 0; b < 4; b++)
          if (be[b]) hex_q[hex_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  // Data memory has no reset so it can map onto block RAM
  always_ff @(posedge clk_i) begin
    if (wr_en && hit_dm)
      for (int b = 0; b < 4; b++)
        if (be[b]) dm_q[dm_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
  end

`ifdef LSU_TIMER_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                tmr_q <= '0;
    else if (wr_en && hit_tmr)  tmr_q <= bus.req_wdata_i;
    else                        tmr_q <= tmr_q + 32'd1;
  end
`endif

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = hex_q[g];
  end
endmodule

// File: tb/tb_lsu_mmio.sv
// tb/tb_lsu_mmio.sv - scoreboard bench for lsu_mmio against a byte-level reference model
`timescale 1ns/1ps
module tb_lsu_mmio;
  localparam int unsigned AW       = 12;
  localparam int unsigned DM_BYTES = 2048;
  localparam int unsigned NUM_HEX  = 8;
  localparam int unsigned SW_W     = 8;
  localparam int unsigned PB       = 'h800;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [SW_W-1:0]       sw = '0;
  logic [32*NUM_HEX-1:0] hex;

  lsu_mmio_if #(.AW(AW)) bus ();

  lsu_mmio #(
    .AW(AW), .DM_BYTES(DM_BYTES), .NUM_HEX(NUM_HEX), .SW_W(SW_W), .PERI_BASE(PB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .io_sw_i(sw), .io_hex_o(hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  m_dm [DM_BYTES];
  logic [7:0]  m_hex [4*NUM_HEX];
  logic [31:0] m_sw = '0;
  logic [31:0] tmr_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian, access size from funct3
  function automatic exp_t model(input bit we, input int unsigned a,
                                 input logic [31:0] wd, input logic [2:0] f3);
    exp_t        e;
    int          sz;
    int          region;
    int unsigned w;
    logic [31:0] v;
    logic [7:0]  b;
    e.rdata = '0;
    e.err   = 1'b0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    w = a / 4;
    if (a < DM_BYTES)                              region = 1;
    else if (w >= PB/4 && w < PB/4 + NUM_HEX)      region = 2;
    else if (w == (PB + 'h80) / 4)                 region = 3;
`ifdef LSU_TIMER_EN
    else if (w == (PB + 'h90) / 4)                 region = 4;
`endif
    else                                           region = 0;
    if (sz == 0 || (a % sz) != 0 || region == 0 || (we && region == 3) ||
        (we && region == 4 && sz != 4)) begin
      e.err = 1'b1;
      return e;
    end
    if (we) begin
      for (int i = 0; i < sz; i++) begin
        if (region == 1)      m_dm[a + i]       = wd[8*i +: 8];
        else if (region == 2) m_hex[a - PB + i] = wd[8*i +: 8];
      end
      return e;
    end
    v = '0;
    for (int i = 0; i < sz; i++) begin
      case (region)
        1:       b = m_dm[a + i];
        2:       b = m_hex[a - PB + i];
        3:       b = m_sw[8*((a % 4) + i) +: 8];
        default: b = tmr_exp[8*((a % 4) + i) +: 8];
      endcase
      v = v | (32'(b) << (8*i));
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    e.rdata = v;
    return e;
  endfunction

  task automatic req(input bit we, input int unsigned a, input logic [31:0] wd, input logic [2:0] f3);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_i   = a[AW-1:0];
    bus.req_wdata_i  = wd;
    bus.req_funct3_i = f3;
    sb.push_back(model(we, a, wd, f3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic check_hex(input string tag);
    for (int i = 0; i < NUM_HEX; i++)
      check($sformatf("%s_hex%0d", tag, i), hex[32*i +: 32],
            {m_hex[4*i+3], m_hex[4*i+2], m_hex[4*i+1], m_hex[4*i]});
  endtask

  // Monitor: each response is due exactly one cycle after its request
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.resp_valid_o) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_resp: got valid 1, expected 0");
          end else begin
            mon_e = sb.pop_front();
            check("resp_rdata", bus.resp_rdata_o, mon_e.rdata);
            check("resp_err", 32'(bus.resp_err_o), 32'(mon_e.err));
          end
        end else if (sb.size() != 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_resp: got valid 0, expected 1");
          mon_e = sb.pop_front();
        end
      end
    end
  end

  initial begin
    int unsigned a;
    logic [2:0]  f3;
    bit          we;
    exp_t        e;

    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_funct3_i = '0;
    for (int i = 0; i < 4*NUM_HEX; i++) m_hex[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst_rdata", bus.resp_rdata_o, 32'd0);
    check("rst_err", 32'(bus.resp_err_o), 32'd0);
    check_hex("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);
    check("idle_valid", 32'(bus.resp_valid_o), 32'd0);

    for (int i = 0; i < 64; i++) req(1'b1, 4*i, $urandom, 3'd2);
    req(1'b1, DM_BYTES - 8, $urandom, 3'd2);
    req(1'b1, DM_BYTES - 4, $urandom, 3'd2);

    req(1'b1, 'h10, 32'hDEAD_BEEF, 3'd2);
    req(1'b0, 'h10, 0, 3'd2);
    req(1'b0, 'h13, 0, 3'd0);
    req(1'b0, 'h13, 0, 3'd4);
    req(1'b0, 'h12, 0, 3'd1);
    req(1'b0, 'h12, 0, 3'd5);

    req(1'b1, PB + 12, 32'h0000_003F, 3'd2);
    req(1'b1, PB + 14, 32'h0000_00A5, 3'd0);
    req(1'b0, PB + 12, 0, 3'd2);
    idle(2);
    check("hex3_direct", hex[32*3 +: 32], 32'h00A5_003F);
    check_hex("dir");

    req(1'b0, 'h11, 0, 3'd1);
    req(1'b0, 'h10, 0, 3'd2);
    req(1'b1, 'h22, 32'h1234_5678, 3'd2);
    req(1'b0, 'h20, 0, 3'd2);
    req(1'b0, PB + 'h40, 0, 3'd2);
    req(1'b1, PB + 'h80, 32'hFF, 3'd2);
    req(1'b0, PB + 'h80, 0, 3'd2);
    req(1'b0, 'h10, 0, 3'd3);
    req(1'b1, 'h10, 32'h1, 3'd7);
    req(1'b0, 'h10, 0, 3'd2);
    req(1'b0, PB + 'h90, 0, 3'd2);

    idle(1);
    sw   = 8'h5A;
    m_sw = 32'h5A;
    idle(2);
    req(1'b0, PB + 'h80, 0, 3'd2);

`ifdef LSU_TIMER_EN
    req(1'b1, PB + 'h90, 32'hFFFF_FFFE, 3'd2);
    idle(1);
    tmr_exp = 32'hFFFF_FFFF;
    req(1'b0, PB + 'h90, 0, 3'd2);
    tmr_exp = 32'h0;
    req(1'b0, PB + 'h90, 0, 3'd2);
    req(1'b1, PB + 'h90, 32'h1, 3'd0);
`endif

    idle(1);
    sw   = SW_W'($urandom);
    m_sw = 32'(sw);
    idle(3);
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = $urandom_range(0, 255);
        5:             a = DM_BYTES - 8 + $urandom_range(0, 7);
        6, 7:          a = PB + $urandom_range(0, 4*NUM_HEX - 1);
        8:             a = PB + 'h80 + $urandom_range(0, 3);
        default:       a = $urandom_range(PB + 4*NUM_HEX, 2**AW - 1);
      endcase
`ifdef LSU_TIMER_EN
      if (a / 4 == (PB + 'h90) / 4) a = PB + 'h40;
`endif
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      req(we, a, $urandom, f3);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check_hex("rand");

    mon_en = 1'b0;
    e = model(1'b0, 'h10, 0, 3'd2);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = 'h10;
    bus.req_funct3_i = 3'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("pre_rst_valid", 32'(bus.resp_valid_o), 32'd1);
    check("pre_rst_rdata", bus.resp_rdata_o, e.rdata);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.resp_valid_o), 32'd0);
    check("mid_rst_rdata", bus.resp_rdata_o, 32'd0);
    for (int i = 0; i < 4*NUM_HEX; i++) m_hex[i] = '0;
    check_hex("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
